pipe_control_unit: RTL and testbench

Parametrised successor to the pipelined MIPS decode-stage control unit. It decodes Op/Funct in the Decode stage and resolves branch/jump in D. It also carries the E/M/W control bits through its own pipeline registers with bubble insertion on flush. Adds optional BNE, immediate-logic and JAL support, illegal-opcode flagging, and a saturating retired-instruction counter.

---
 rtl/mips_ctrl_pkg.sv | 58 +++++
 rtl/ctrl_decode.sv | 113 +++++++++++
 rtl/pipe_control_unit.sv | 117 +++++++++++
 tb/tb_pipe_control_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcodes, ALU codes and E/M/W control bundle
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic       memWrite;
    logic       aluSrc;
    logic [1:0] regDst;
    logic [3:0] aluCtrl;
    logic       link;
    logic       valid;
    logic       illegal;
  } CtrlBundle;

  function automatic logic [3:0] aluForFunct(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_NOR:  return ALU_NOR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational main/ALU decoder with parameter-gated legality
module ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter bit EN_BNE       = 1'b1,
  parameter bit EN_IMM_LOGIC = 1'b1,
  parameter bit EN_JAL       = 1'b1
) (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       equal,
  output CtrlBundle  ctrl,
  output logic       pcSrc,
  output logic       jump,
  output logic       branch,
  output logic       extZero,
  output logic       illegal
);

  logic bad;
  logic isBne;

  always_comb begin
    ctrl         = '0;
    ctrl.valid   = 1'b1;
    ctrl.aluCtrl = ALU_ADD;
    ctrl.regDst  = REGDST_RT;
    jump         = 1'b0;
    branch       = 1'b0;
    extZero      = 1'b0;
    isBne        = 1'b0;
    bad          = 1'b0;

    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_NOP: ;
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: begin
            ctrl.regWrite = 1'b1;
            ctrl.regDst   = REGDST_RD;
            ctrl.aluCtrl  = aluForFunct(funct);
          end
          default: bad = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b1;
        ctrl.aluSrc   = 1'b1;
      end
      OP_SW: begin
        ctrl.memWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
      end
      OP_ADDI: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
      end
      OP_SLTI: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.aluCtrl  = ALU_SLT;
      end
      OP_ANDI, OP_ORI: begin
        if (EN_IMM_LOGIC) begin
          ctrl.regWrite = 1'b1;
          ctrl.aluSrc   = 1'b1;
          ctrl.aluCtrl  = (op == OP_ANDI) ? ALU_AND : ALU_OR;
          extZero       = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      OP_BEQ: branch = 1'b1;
      OP_BNE: begin
        if (EN_BNE) begin
          branch = 1'b1;
          isBne  = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      OP_J: jump = 1'b1;
      OP_JAL: begin
        if (EN_JAL) begin
          jump          = 1'b1;
          ctrl.regWrite = 1'b1;
          ctrl.regDst   = REGDST_RA;
          ctrl.link     = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase

    // Illegal instructions still travel down the pipe so IllegalW can flag them.
    if (bad) begin
      ctrl         = '0;
      ctrl.valid   = 1'b1;
      ctrl.illegal = 1'b1;
      ctrl.aluCtrl = ALU_ADD;
      jump         = 1'b0;
      branch       = 1'b0;
      extZero      = 1'b0;
      isBne        = 1'b0;
    end

    illegal = bad;
    pcSrc   = branch & (equal ^ isBne);
  end

endmodule

// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - decode-stage control with E/M/W pipeline and retire counter
module pipe_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W   = 4,
  parameter int CNT_W        = 32,
  parameter bit EN_BNE       = 1'b1,
  parameter bit EN_IMM_LOGIC = 1'b1,
  parameter bit EN_JAL       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            Op,
  input  logic [5:0]            Funct,
  input  logic                  EqualD,
  input  logic                  FlushE,
  output logic                  PCSrcD,
  output logic                  JumpD,
  output logic                  BranchD,
  output logic                  ExtZeroD,
  output logic                  IllegalD,
  output logic                  RegWriteE,
  output logic                  MemToRegE,
  output logic                  MemWriteE,
  output logic                  ALUSrcE,
  output logic                  ValidE,
  output logic [1:0]            RegDstE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  RegWriteM,
  output logic                  MemToRegM,
  output logic                  MemWriteM,
  output logic                  ValidM,
  output logic                  RegWriteW,
  output logic                  MemToRegW,
  output logic                  LinkW,
  output logic                  ValidW,
  output logic                  IllegalW,
  output logic [CNT_W-1:0]      RetiredCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  CtrlBundle ctrlD;
  CtrlBundle ctrlE;
  logic      linkM;
  logic      illegalM;

  ctrl_decode #(
    .EN_BNE      (EN_BNE),
    .EN_IMM_LOGIC(EN_IMM_LOGIC),
    .EN_JAL      (EN_JAL)
  ) uDecode (
    .op     (Op),
    .funct  (Funct),
    .equal  (EqualD),
    .ctrl   (ctrlD),
    .pcSrc  (PCSrcD),
    .jump   (JumpD),
    .branch (BranchD),
    .extZero(ExtZeroD),
    .illegal(IllegalD)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrlE <= '0;
    end else begin
      ctrlE <= FlushE ? '0 : ctrlD;
    end
  end

  // M and W keep only the bits still consumed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM <= 1'b0;
      MemToRegM <= 1'b0;
      MemWriteM <= 1'b0;
      ValidM    <= 1'b0;
      linkM     <= 1'b0;
      illegalM  <= 1'b0;
      RegWriteW <= 1'b0;
      MemToRegW <= 1'b0;
      LinkW     <= 1'b0;
      ValidW    <= 1'b0;
      IllegalW  <= 1'b0;
    end else begin
      RegWriteM <= ctrlE.regWrite;
      MemToRegM <= ctrlE.memToReg;
      MemWriteM <= ctrlE.memWrite;
      ValidM    <= ctrlE.valid;
      linkM     <= ctrlE.link;
      illegalM  <= ctrlE.illegal;
      RegWriteW <= RegWriteM;
      MemToRegW <= MemToRegM;
      LinkW     <= linkM;
      ValidW    <= ValidM;
      IllegalW  <= illegalM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RetiredCount <= '0;
    end else if (ValidW && !IllegalW && (RetiredCount != CNT_MAX)) begin
      RetiredCount <= RetiredCount + CNT_W'(1);
    end
  end

  assign RegWriteE   = ctrlE.regWrite;
  assign MemToRegE   = ctrlE.memToReg;
  assign MemWriteE   = ctrlE.memWrite;
  assign ALUSrcE     = ctrlE.aluSrc;
  assign ValidE      = ctrlE.valid;
  assign RegDstE     = ctrlE.regDst;
  assign ALUControlE = ALU_CTRL_W'(ctrlE.aluCtrl);

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb/tb_pipe_control_unit.sv - randomized bench with history-array reference model
module tb_pipe_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       equalD = 1'b0;
  logic       flushE = 1'b0;

  logic PCSrcDA, JumpDA, BranchDA, ExtZeroDA, IllegalDA;
  logic RegWriteEA, MemToRegEA, MemWriteEA, ALUSrcEA, ValidEA;
  logic [1:0] RegDstEA;
  logic [3:0] ALUControlEA;
  logic RegWriteMA, MemToRegMA, MemWriteMA, ValidMA;
  logic RegWriteWA, MemToRegWA, LinkWA, ValidWA, IllegalWA;
  logic [31:0] RetiredCountA;

  logic PCSrcDB, JumpDB, BranchDB, ExtZeroDB, IllegalDB;
  logic RegWriteEB, MemToRegEB, MemWriteEB, ALUSrcEB, ValidEB;
  logic [1:0] RegDstEB;
  logic [5:0] ALUControlEB;
  logic RegWriteMB, MemToRegMB, MemWriteMB, ValidMB;
  logic RegWriteWB, MemToRegWB, LinkWB, ValidWB, IllegalWB;
  logic [3:0] RetiredCountB;

  pipe_control_unit dutA (
    .clk(clk), .rst_n(rst_n), .Op(op), .Funct(funct), .EqualD(equalD), .FlushE(flushE),
    .PCSrcD(PCSrcDA), .JumpD(JumpDA), .BranchD(BranchDA), .ExtZeroD(ExtZeroDA), .IllegalD(IllegalDA),
    .RegWriteE(RegWriteEA), .MemToRegE(MemToRegEA), .MemWriteE(MemWriteEA), .ALUSrcE(ALUSrcEA),
    .ValidE(ValidEA), .RegDstE(RegDstEA), .ALUControlE(ALUControlEA),
    .RegWriteM(RegWriteMA), .MemToRegM(MemToRegMA), .MemWriteM(MemWriteMA), .ValidM(ValidMA),
    .RegWriteW(RegWriteWA), .MemToRegW(MemToRegWA), .LinkW(LinkWA), .ValidW(ValidWA),
    .IllegalW(IllegalWA), .RetiredCount(RetiredCountA)
  );

  pipe_control_unit #(
    .ALU_CTRL_W(6), .CNT_W(4), .EN_BNE(1'b0), .EN_IMM_LOGIC(1'b0), .EN_JAL(1'b0)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .Op(op), .Funct(funct), .EqualD(equalD), .FlushE(flushE),
    .PCSrcD(PCSrcDB), .JumpD(JumpDB), .BranchD(BranchDB), .ExtZeroD(ExtZeroDB), .IllegalD(IllegalDB),
    .RegWriteE(RegWriteEB), .MemToRegE(MemToRegEB), .MemWriteE(MemWriteEB), .ALUSrcE(ALUSrcEB),
    .ValidE(ValidEB), .RegDstE(RegDstEB), .ALUControlE(ALUControlEB),
    .RegWriteM(RegWriteMB), .MemToRegM(MemToRegMB), .MemWriteM(MemWriteMB), .ValidM(ValidMB),
    .RegWriteW(RegWriteWB), .MemToRegW(MemToRegWB), .LinkW(LinkWB), .ValidW(ValidWB),
    .IllegalW(IllegalWB), .RetiredCount(RetiredCountB)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic       memWrite;
    logic       aluSrc;
    logic [1:0] regDst;
    logic [3:0] alu;
    logic       link;
    logic       valid;
    logic       illegal;
    logic       jump;
    logic       branch;
    logic       extZero;
  } exp_t;

  // hist[c] is what the E register captured at the edge that ends cycle c.
  exp_t    histA [0:4095];
  exp_t    histB [0:4095];
  int      cyc = 0;
  longint  expCntA = 0;
  int      expCntB = 0;
  bit      chkEn = 1'b0;
  int      checks = 0;
  int      errors = 0;
  logic [5:0] opTab [16];
  logic [5:0] fnTab [8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // Instruction table from the ISA description; disabled features fall to illegal.
  function automatic exp_t model(input logic [5:0] o, input logic [5:0] f,
                                 input bit enBne, input bit enImm, input bit enJal);
    exp_t r;
    bit   legal;
    r = '0;
    r.valid = 1'b1;
    r.alu = 4'b0010;
    legal = 1'b1;
    if (o == 6'h00) begin
      if (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h27 || f == 6'h2A) begin
        r.regWrite = 1'b1;
        r.regDst = 2'b01;
        r.alu = (f == 6'h22) ? 4'b0110 : (f == 6'h24) ? 4'b0000 : (f == 6'h25) ? 4'b0001 :
                (f == 6'h27) ? 4'b1100 : (f == 6'h2A) ? 4'b0111 : 4'b0010;
      end else if (f != 6'h00) begin
        legal = 1'b0;
      end
    end else if (o == 6'h23) begin
      r.regWrite = 1'b1; r.memToReg = 1'b1; r.aluSrc = 1'b1;
    end else if (o == 6'h2B) begin
      r.memWrite = 1'b1; r.aluSrc = 1'b1;
    end else if (o == 6'h08 || o == 6'h0A) begin
      r.regWrite = 1'b1; r.aluSrc = 1'b1;
      if (o == 6'h0A) r.alu = 4'b0111;
    end else if ((o == 6'h0C || o == 6'h0D) && enImm) begin
      r.regWrite = 1'b1; r.aluSrc = 1'b1; r.extZero = 1'b1;
      r.alu = (o == 6'h0C) ? 4'b0000 : 4'b0001;
    end else if (o == 6'h04 || (o == 6'h05 && enBne)) begin
      r.branch = 1'b1;
    end else if (o == 6'h02) begin
      r.jump = 1'b1;
    end else if (o == 6'h03 && enJal) begin
      r.jump = 1'b1; r.regWrite = 1'b1; r.regDst = 2'b10; r.link = 1'b1;
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin
      r = '0;
      r.valid = 1'b1;
      r.illegal = 1'b1;
      r.alu = 4'b0010;
    end
    return r;
  endfunction

  function automatic exp_t getH(input bit b, input int idx);
    if (idx < 0) return '0;
    return b ? histB[idx] : histA[idx];
  endfunction

  task automatic cmpDut(input string tag, input bit b, input logic [6:0] gotE, input logic [7:0] gotAlu,
                        input logic [3:0] gotM, input logic [4:0] gotW, input logic [63:0] gotCnt,
                        input logic [4:0] gotD);
    exp_t e, m, w, d;
    logic pc;
    e = getH(b, cyc - 1);
    m = getH(b, cyc - 2);
    w = getH(b, cyc - 3);
    d = model(op, funct, !b, !b, !b);
    pc = d.branch & ((op == 6'h05) ? ~equalD : equalD);
    chk({tag, ".E"}, 64'(gotE), 64'({e.regWrite, e.memToReg, e.memWrite, e.aluSrc, e.regDst, e.valid}));
    chk({tag, ".aluE"}, 64'(gotAlu), 64'(e.alu));
    chk({tag, ".M"}, 64'(gotM), 64'({m.regWrite, m.memToReg, m.memWrite, m.valid}));
    chk({tag, ".W"}, 64'(gotW), 64'({w.regWrite, w.memToReg, w.link, w.valid, w.illegal}));
    chk({tag, ".cnt"}, gotCnt, b ? 64'(expCntB) : 64'(expCntA));
    chk({tag, ".D"}, 64'(gotD), 64'({pc, d.jump, d.branch, d.extZero, d.illegal}));
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      cmpDut("A", 1'b0, {RegWriteEA, MemToRegEA, MemWriteEA, ALUSrcEA, RegDstEA, ValidEA},
             8'(ALUControlEA), {RegWriteMA, MemToRegMA, MemWriteMA, ValidMA},
             {RegWriteWA, MemToRegWA, LinkWA, ValidWA, IllegalWA}, 64'(RetiredCountA),
             {PCSrcDA, JumpDA, BranchDA, ExtZeroDA, IllegalDA});
      cmpDut("B", 1'b1, {RegWriteEB, MemToRegEB, MemWriteEB, ALUSrcEB, RegDstEB, ValidEB},
             8'(ALUControlEB), {RegWriteMB, MemToRegMB, MemWriteMB, ValidMB},
             {RegWriteWB, MemToRegWB, LinkWB, ValidWB, IllegalWB}, 64'(RetiredCountB),
             {PCSrcDB, JumpDB, BranchDB, ExtZeroDB, IllegalDB});
    end
  end

  // Called just after a rising edge; leaves the inputs settled until the next edge.
  task automatic drive(input logic [5:0] o, input logic [5:0] f, input bit eq, input bit fl);
    op = o;
    funct = f;
    equalD = eq;
    flushE = fl;
    if (!rst_n || fl) begin
      histA[cyc] = '0;
      histB[cyc] = '0;
    end else begin
      histA[cyc] = model(o, f, 1'b1, 1'b1, 1'b1);
      histB[cyc] = model(o, f, 1'b0, 1'b0, 1'b0);
    end
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && cyc >= 3) begin
      if (histA[cyc-3].valid && !histA[cyc-3].illegal) expCntA++;
      if (histB[cyc-3].valid && !histB[cyc-3].illegal && expCntB < 15) expCntB++;
    end
    cyc++;
    #1;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(6'h00, 6'h00, 1'b0, 1'b1);
      tick();
    end
  endtask

  task automatic randCycles(input int n);
    logic [5:0] o, f;
    for (int i = 0; i < n; i++) begin
      int oi, fi;
      oi = $urandom_range(0, 15);
      fi = $urandom_range(0, 7);
      o = (oi >= 14) ? 6'($urandom_range(0, 63)) : opTab[oi];
      f = (fi == 7) ? 6'($urandom_range(0, 63)) : fnTab[fi];
      drive(o, f, 1'($urandom_range(0, 1)), ($urandom_range(0, 6) == 0));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    opTab = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0A, 6'h0C,
              6'h0D, 6'h04, 6'h05, 6'h02, 6'h03, 6'h00, 6'h00, 6'h00};
    fnTab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h00};
    for (int i = 0; i < 4096; i++) begin
      histA[i] = '0;
      histB[i] = '0;
    end
    #1;
    chkEn = 1'b1;
    drive(6'h00, 6'h20, 1'b0, 1'b0);
    chk("resetE", 64'({ValidEA, RegWriteEA, ALUControlEA}), 64'd0);
    chk("resetCnt", 64'({RetiredCountA, RetiredCountB}), 64'd0);
    tick();
    drive(6'h00, 6'h20, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;

    // add at n: E at n+1, W at n+3, counted by n+4
    drive(6'h00, 6'h20, 1'b0, 1'b0);
    tick();
    drive(6'h00, 6'h00, 1'b0, 1'b1);
    chk("addRegWriteE", 64'(RegWriteEA), 64'd1);
    chk("addRegDstE", 64'(RegDstEA), 64'd1);
    chk("addAluE", 64'(ALUControlEA), 64'h2);
    tick();
    bubbles(1);
    drive(6'h00, 6'h00, 1'b0, 1'b1);
    chk("addRegWriteW", 64'(RegWriteWA), 64'd1);
    tick();
    drive(6'h00, 6'h00, 1'b0, 1'b1);
    chk("addCount", 64'(RetiredCountA), 64'd1);
    tick();

    drive(6'h04, 6'h00, 1'b1, 1'b1);
    chk("beqEq1", 64'(PCSrcDA), 64'd1);
    tick();
    drive(6'h04, 6'h00, 1'b0, 1'b1);
    chk("beqEq0", 64'(PCSrcDA), 64'd0);
    tick();
    drive(6'h05, 6'h00, 1'b0, 1'b1);
    chk("bneEq0", 64'(PCSrcDA), 64'd1);
    tick();
    // bne with EN_BNE=0 travels as illegal and is never counted
    drive(6'h05, 6'h00, 1'b0, 1'b0);
    chk("bneIllegalD", 64'({IllegalDB, PCSrcDB}), 64'b10);
    tick();
    bubbles(2);
    drive(6'h00, 6'h00, 1'b0, 1'b1);
    chk("bneIllegalW", 64'({IllegalWB, ValidWB, IllegalWA}), 64'b110);
    tick();
    drive(6'h00, 6'h00, 1'b0, 1'b1);
    chk("bneCount", 64'({RetiredCountA, RetiredCountB}), {28'd0, 32'd2, 4'd1});
    tick();

    drive(6'h23, 6'h00, 1'b0, 1'b1);
    tick();
    drive(6'h00, 6'h00, 1'b0, 1'b1);
    chk("lwFlushE", 64'({ValidEA, MemToRegEA}), 64'd0);
    tick();
    bubbles(2);
    drive(6'h00, 6'h00, 1'b0, 1'b1);
    chk("lwFlushCount", 64'(RetiredCountA), 64'd2);
    tick();

    drive(6'h03, 6'h00, 1'b0, 1'b0);
    chk("jalJumpD", 64'({JumpDA, JumpDB, IllegalDB}), 64'b101);
    tick();
    drive(6'h0D, 6'h00, 1'b0, 1'b1);
    chk("jalRegDstE", 64'(RegDstEA), 64'd2);
    chk("oriExtZeroD", 64'({ExtZeroDA, ExtZeroDB, IllegalDB}), 64'b101);
    tick();
    drive(6'h0D, 6'h00, 1'b0, 1'b0);
    tick();
    drive(6'h00, 6'h00, 1'b0, 1'b1);
    chk("jalW", 64'({RegWriteWA, LinkWA, IllegalWB}), 64'b111);
    chk("oriAluE", 64'(ALUControlEA), 64'h1);
    tick();

    for (int i = 0; i < 20; i++) begin
      drive(6'h00, 6'h20, 1'b0, 1'b0);
      tick();
    end
    bubbles(3);
    drive(6'h00, 6'h00, 1'b0, 1'b1);
    chk("satCountB", 64'(RetiredCountB), 64'd15);
    tick();

    randCycles(400);

    // asynchronous reset mid-stream drops everything in flight
    drive(6'h00, 6'h20, 1'b0, 1'b0);
    rst_n = 1'b0;
    for (int i = cyc - 3; i <= cyc; i++) begin
      if (i >= 0) begin
        histA[i] = '0;
        histB[i] = '0;
      end
    end
    expCntA = 0;
    expCntB = 0;
    #1;
    chk("asyncRstA", 64'({RegWriteEA, ValidEA, ALUControlEA, ValidMA, ValidWA, RegWriteWA, RetiredCountA}), 64'd0);
    chk("asyncRstB", 64'({ValidEB, ALUControlEB, ValidMB, ValidWB, IllegalWB, RetiredCountB}), 64'd0);
    tick();
    drive(6'h23, 6'h00, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;

    randCycles(400);
    bubbles(4);

    chkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
